// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller:
// register offsets, default geometry and the "no interrupt" ID.
package irq_ctrl_pkg;

  localparam int NSRC_DEF   = 8;
  localparam int PRIO_W_DEF = 3;
  localparam int ID_NONE    = 0;

  localparam logic [7:0] ADDR_PEND  = 8'h40;
  localparam logic [7:0] ADDR_EN    = 8'h44;
  localparam logic [7:0] ADDR_THR   = 8'h48;
  localparam logic [7:0] ADDR_CLAIM = 8'h4C;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: 2-flop synchronizer, pending latch and
// in-service flag driven by claim/complete pulses.
module irq_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic sync1;
  logic sync2;
  logic in_service;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      // a claim always wins over a fresh set of the same source
      if (claim)
        pending <= 1'b0;
      else if (sync2 && !in_service)
        pending <= 1'b1;
      if (claim)
        in_service <= 1'b1;
      else if (complete)
        in_service <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: register decode, priority arbitration
// and the registered mei_pending request.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC   = NSRC_DEF,
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   irq_src,
  input  logic [7:0]        addr,
  input  logic [31:0]       wdata,
  input  logic              wenable,
  input  logic              renable,
  output logic [31:0]       rdata,
  output logic              mei_pending
);

  localparam int ID_W = $clog2(NSRC + 1);

  logic [PRIO_W-1:0] prio_q [NSRC:1];
  logic [PRIO_W-1:0] thr_q;
  logic [NSRC:1]     en_q;
  logic [NSRC:1]     pend;
  logic [NSRC:1]     claim;
  logic [NSRC:1]     compl;
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [7:0]        a;
  logic              unused_bits;

  assign a           = {addr[7:2], 2'b00};
  assign unused_bits = ^{wdata, addr[1:0]};

  for (genvar i = 1; i <= NSRC; i++) begin : g_gw
    irq_gateway u_gw (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (irq_src[i-1]),
      .claim    (claim[i]),
      .complete (compl[i]),
      .pending  (pend[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NSRC; i++)
        prio_q[i] <= '0;
      thr_q <= '0;
      en_q  <= '0;
    end else if (wenable) begin
      for (int i = 1; i <= NSRC; i++)
        if (a == 8'(4 * i))
          prio_q[i] <= wdata[PRIO_W-1:0];
      if (a == ADDR_EN)
        en_q <= wdata[NSRC:1];
      if (a == ADDR_THR)
        thr_q <= wdata[PRIO_W-1:0];
    end
  end

  // strictly-greater update keeps the lowest ID on ties
  always_comb begin
    best_id   = ID_W'(ID_NONE);
    best_prio = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (pend[i] && en_q[i] &&
          prio_q[i] != '0 &&
          prio_q[i] > thr_q &&
          prio_q[i] > best_prio) begin
        best_id   = ID_W'(i);
        best_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    claim = '0;
    compl = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (renable && a == ADDR_CLAIM &&
          best_id == ID_W'(i))
        claim[i] = 1'b1;
      if (wenable && a == ADDR_CLAIM &&
          wdata[7:0] == 8'(i))
        compl[i] = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      a == ADDR_PEND:  rdata[NSRC:0] = {pend, 1'b0};
      a == ADDR_EN:    rdata[NSRC:0] = {en_q, 1'b0};
      a == ADDR_THR:   rdata[PRIO_W-1:0] = thr_q;
      a == ADDR_CLAIM: rdata[ID_W-1:0] = best_id;
      default: begin
        for (int i = 1; i <= NSRC; i++)
          if (a == 8'(4 * i))
            rdata[PRIO_W-1:0] = prio_q[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mei_pending <= 1'b0;
    else
      mei_pending <= (best_id != ID_W'(ID_NONE));
  end

endmodule
